// File: rtl/tpu_apb_pkg.sv
// Shared state type and TPU register map for the TPU APB requester.
package tpu_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int TPU_NUM_WEIGHTS = 4;
    localparam int TPU_WEIGHT_BASE = 0;
    localparam int TPU_RESULT_ADDR = 0;
    localparam int TPU_START_ADDR  = 4;

    function automatic int tpu_weight_addr(input int idx);
        return TPU_WEIGHT_BASE + idx;
    endfunction

endpackage

// File: rtl/tpu_apb_master.sv
// Single-outstanding APB requester for the TPU register block.
// Optional ACCESS watchdog enabled by defining TPU_APB_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | bus parked at zero, cmd_ready high
// ST_SETUP  | psel=1, penable=0, latched command on the bus
// ST_ACCESS | psel=1, penable=1, wait for pready (or watchdog expiry)
module tpu_apb_master
    import tpu_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    apb_state_e        state;
    logic              xfer_done;
    logic              done_err;
    logic [DATA_W-1:0] done_rdata;

`ifdef TPU_APB_TIMEOUT_EN
    // Down-counter loaded on entry to ACCESS; expiry at terminal count zero.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0]            wdog;
`endif

    always_comb begin
        xfer_done  = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        if (state == ST_ACCESS) begin
            if (i_pready) begin
                xfer_done  = 1'b1;
                done_err   = i_pslverr;
                done_rdata = o_pwrite ? '0 : i_prdata;
            end
`ifdef TPU_APB_TIMEOUT_EN
            else if (wdog == '0) begin
                xfer_done = 1'b1;
                done_err  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_paddr     <= '0;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_pwdata    <= '0;
`ifdef TPU_APB_TIMEOUT_EN
            wdog        <= '0;
`endif
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_cmd_ready <= 1'b1;
                    if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready <= 1'b0;
                        o_psel      <= 1'b1;
                        o_paddr     <= i_cmd_addr;
                        o_pwrite    <= i_cmd_write;
                        o_pwdata    <= i_cmd_write ? i_cmd_wdata : '0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    o_penable <= 1'b1;
                    state     <= ST_ACCESS;
`ifdef TPU_APB_TIMEOUT_EN
                    wdog      <= WD_LOAD;
`endif
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= done_rdata;
                        o_rsp_err   <= done_err;
                        o_cmd_ready <= 1'b1;
                        o_psel      <= 1'b0;
                        o_penable   <= 1'b0;
                        o_pwrite    <= 1'b0;
                        o_paddr     <= '0;
                        o_pwdata    <= '0;
                        state       <= ST_IDLE;
                    end
`ifdef TPU_APB_TIMEOUT_EN
                    else begin
                        wdog <= wdog - 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_apb_master.sv
// Scoreboard bench for tpu_apb_master: random and directed APB traffic
// against a behavioural slave, memory reference model and TPU matmul slave.
module tb_tpu_apb_master;
    import tpu_apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    always #5 clk = ~clk;

    tpu_apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_write(cmd_write),
        .i_cmd_addr (cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err  (rsp_err),
        .o_paddr    (paddr),
        .o_psel     (psel),
        .o_penable  (penable),
        .o_pwrite   (pwrite),
        .o_pwdata   (pwdata),
        .i_prdata   (prdata),
        .i_pready   (pready),
        .i_pslverr  (pslverr)
    );

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                lat;
    } exp_t;

    typedef struct packed {
        int   waits;
        logic err;
    } slv_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    slv_t slv_q[$];

    logic              cur_write = 1'b0;
    logic [ADDR_W-1:0] cur_addr  = '0;
    logic [DATA_W-1:0] cur_wdata = '0;
    int                cur_acc   = 0;

    logic [DATA_W-1:0] slv_mem   [16];
    logic [DATA_W-1:0] model_mem [16];
    logic              tpu_mode = 1'b0;
    int                tpu_w [4];
    int                tpu_x [2][2] = '{'{5, 6}, '{7, 8}};
    logic [DATA_W-1:0] tpu_res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drives one command from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int waits, input logic err, input logic tracked,
                         input logic [DATA_W-1:0] exp_rdata, input logic exp_err, input int exp_lat);
        int   n = 0;
        exp_t e;
        slv_t s;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_accept: actual cmd_ready=0 after %0d cycles, required 1", n);
            cmd_valid = 1'b0;
            return;
        end
        cur_write = wr;
        cur_addr  = addr;
        cur_wdata = wr ? wdata : '0;
        cur_acc   = cyc;
        s.waits   = waits;
        s.err     = err;
        slv_q.push_back(s);
        if (tracked) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: actual %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic reset_mid_access(input int hold_cycles);
        int n = 0;
        issue(1'b0, 32'h3, 32'h0, 1000, 1'b0, 1'b0, '0, 1'b0, 0);
        while (!(psel && penable) && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (hold_cycles) @(negedge clk);
        check("access_held", 128'({psel, penable}), 128'(2'b11));
        #2 rstn = 1'b0;
        #1;
        check("abort_ctrl", 128'({cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite}), 128'(0));
        check("abort_bus", 128'({paddr, pwdata}), 128'(0));
        check("abort_rdata", 128'(rsp_rdata), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 128'(cmd_ready), 128'(1));
    endtask

    initial begin : slave
        slv_t p;
        int   waits_left;
        logic cur_err;
        waits_left = 0;
        cur_err    = 1'b0;
        pready     = 1'b0;
        prdata     = '0;
        pslverr    = 1'b0;
        forever begin
            @(negedge clk);
            if (psel && !penable) begin
                if (slv_q.size() > 0) p = slv_q.pop_front();
                else begin
                    p.waits = 0;
                    p.err   = 1'b0;
                end
                waits_left = p.waits;
                cur_err    = p.err;
                pready     = 1'($urandom_range(0, 1));
                prdata     = $urandom;
                pslverr    = 1'($urandom_range(0, 1));
            end else if (psel && penable && waits_left == 0) begin
                pready  = 1'b1;
                pslverr = cur_err;
                prdata  = $urandom;
                if (tpu_mode) begin
                    if (!pwrite) begin
                        if (paddr == TPU_RESULT_ADDR && tpu_res_q.size() > 0) prdata = tpu_res_q.pop_front();
                    end else if (paddr == TPU_START_ADDR) begin
                        tpu_res_q.delete();
                        for (int r = 0; r < 2; r++)
                            for (int c = 0; c < 2; c++)
                                tpu_res_q.push_back(DATA_W'(tpu_w[2*r] * tpu_x[0][c] + tpu_w[2*r+1] * tpu_x[1][c]));
                    end else if (paddr < TPU_NUM_WEIGHTS) begin
                        tpu_w[paddr[1:0]] = int'(pwdata);
                    end
                end else if (!pwrite) begin
                    prdata = slv_mem[paddr[3:0]];
                end else if (!cur_err) begin
                    slv_mem[paddr[3:0]] = pwdata;
                end
                waits_left = -1;
            end else if (psel && penable) begin
                pready     = 1'b0;
                waits_left = waits_left - 1;
                prdata     = $urandom;
                pslverr    = 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : monitor
        exp_t              e;
        int                a;
        logic              prev_valid;
        logic [DATA_W-1:0] last_rd;
        logic              last_err;
        prev_valid = 1'b0;
        last_rd    = '0;
        last_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_valid = 1'b0;
                last_rd    = '0;
                last_err   = 1'b0;
            end else begin
                if (rsp_valid) begin
                    check("rsp_pulse_width", 128'(prev_valid), 128'(0));
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: actual rsp_valid=1 rdata 0x%0h, required no response", rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
                        check("rsp_err", 128'(rsp_err), 128'(e.err));
                        check("rsp_latency", 128'(cyc - a), 128'(e.lat));
                    end
                    last_rd  = rsp_rdata;
                    last_err = rsp_err;
                end else begin
                    check("rsp_hold", 128'({rsp_rdata, rsp_err}), 128'({last_rd, last_err}));
                end
                prev_valid = rsp_valid;
                if (!psel) begin
                    check("idle_bus", 128'({penable, pwrite, paddr, pwdata}), 128'(0));
                end else begin
                    check("bus_stable", 128'({pwrite, paddr, pwdata}), 128'({cur_write, cur_addr, cur_wdata}));
                    if (!penable) check("setup_cycle", 128'(cyc - cur_acc), 128'(1));
                    else          check("access_cycle", 128'(cyc - cur_acc >= 2), 128'(1));
                end
                check("ready_vs_psel", 128'(cmd_ready && psel), 128'(0));
            end
        end
    end

    initial begin : stim
        logic              wr;
        logic              er;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        int                w;
        logic [DATA_W-1:0] tpu_exp [4];

        for (int i = 0; i < 16; i++) begin
            slv_mem[i]   = 32'h5A00_0000 | (32'(i) * 32'h0101);
            model_mem[i] = 32'h5A00_0000 | (32'(i) * 32'h0101);
        end

        #1 rstn = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 128'({cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite}), 128'(0));
        check("rst_bus", 128'({paddr, pwdata}), 128'(0));
        check("rst_rdata", 128'(rsp_rdata), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 128'(cmd_ready), 128'(1));

        // Zero-wait write, stalled read, erroring read.
        model_mem[2] = 32'h5;
        issue(1'b1, 32'h2, 32'h0000_0005, 0, 1'b0, 1'b1, '0, 1'b0, 3);
        slv_mem[7]   = 32'hDEAD_BEEF;
        model_mem[7] = 32'hDEAD_BEEF;
        issue(1'b0, 32'h7, $urandom, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 6);
        issue(1'b0, 32'h9, $urandom, 1, 1'b1, 1'b1, model_mem[9], 1'b1, 4);
        drain();

        reset_mid_access(2);

`ifdef TPU_APB_TIMEOUT_EN
        issue(1'b0, 32'h3, 32'h0, 1000, 1'b0, 1'b1, '0, 1'b1, 2 + TIMEOUT);
        drain();
`else
        reset_mid_access(100);
`endif

        // Weights [[1,2],[3,4]] times [[5,6],[7,8]] = [[19,22],[43,50]].
        tpu_exp[0] = 32'd19;
        tpu_exp[1] = 32'd22;
        tpu_exp[2] = 32'd43;
        tpu_exp[3] = 32'd50;
        tpu_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(0, 2);
            issue(1'b1, ADDR_W'(tpu_weight_addr(k)), DATA_W'(k + 1), w, 1'b0, 1'b1, '0, 1'b0, 3 + w);
        end
        issue(1'b1, ADDR_W'(TPU_START_ADDR), 32'h1, 0, 1'b0, 1'b1, '0, 1'b0, 3);
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(0, 2);
            issue(1'b0, ADDR_W'(TPU_RESULT_ADDR), $urandom, w, 1'b0, 1'b1, tpu_exp[k], 1'b0, 3 + w);
        end
        drain();
        tpu_mode = 1'b0;

        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, 15));
            d  = $urandom;
            w  = $urandom_range(0, 3);
            er = ($urandom_range(0, 5) == 0);
            if (wr) begin
                exp_rd = '0;
                if (!er) model_mem[a[3:0]] = d;
            end else begin
                exp_rd = model_mem[a[3:0]];
            end
            issue(wr, a, d, w, er, 1'b1, exp_rd, er, 3 + w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL global_timeout: simulation still running at 300000ns, required completion");
        $fatal(1);
    end

endmodule

// File: doc/tpu_apb_master.md
TPU_APB_MASTER -- requirements
Module: tpu_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: APB address width.
REQ-002 SHALL have parameter DATA_W, default 32: APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles waiting for i_pready (used only with TPU_APB_TIMEOUT_EN).
REQ-004 SHALL have port i_clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port i_rstn, input, 1: reset; asynchronous, active-low.
REQ-006 SHALL have port i_cmd_valid, input, 1: command request.
REQ-007 SHALL have port o_cmd_ready, output, 1: command accept; high only in IDLE.
REQ-008 SHALL have port i_cmd_write, input, 1: 1 = APB write, 0 = APB read.
REQ-009 SHALL have port i_cmd_addr, input, ADDR_W: transfer address.
REQ-010 SHALL have port i_cmd_wdata, input, DATA_W: write data.
REQ-011 SHALL have port o_rsp_valid, output, 1: one-cycle completion pulse for every command, read or write.
REQ-012 SHALL have port o_rsp_rdata, output, DATA_W: read data; 0 for writes.
REQ-013 SHALL have port o_rsp_err, output, 1: slave error or timeout for the completed transfer.
REQ-014 SHALL have ports o_paddr (ADDR_W), o_psel (1), o_penable (1), o_pwrite (1) and o_pwdata (DATA_W), all outputs: APB requester signals.
REQ-015 SHALL have ports i_prdata (DATA_W), i_pready (1) and i_pslverr (1), all inputs; a slave without a ready output ties i_pready=1 and i_pslverr=0.

Function
REQ-016 SHALL implement the states IDLE, SETUP, ACCESS, all registered outputs.
REQ-017 In IDLE, i_cmd_valid&o_cmd_ready SHALL latch write, addr and wdata, then move to SETUP.
REQ-018 SETUP SHALL drive o_psel=1 and o_penable=0 with the latched paddr, pwrite and pwdata, then move unconditionally to ACCESS.
REQ-019 ACCESS SHALL drive o_psel=1 and o_penable=1 and hold paddr, pwrite and pwdata stable until i_pready=1.
REQ-020 ACCESS with i_pready=1 SHALL complete the transfer, capture i_prdata (reads only) and i_pslverr, and return to IDLE.
REQ-021 o_rsp_valid SHALL pulse in the cycle after completion; with zero wait states, latency from command accept to o_rsp_valid is 3 cycles.
REQ-022 In IDLE, o_psel, o_penable, o_pwrite, o_paddr and o_pwdata SHALL be 0.
REQ-023 o_pwdata SHALL be 0 during read transfers.
REQ-024 The back-to-back command rate SHALL be one command per 3 cycles (cmd_ready returns in the cycle of the rsp pulse).
REQ-025 i_cmd_valid while not in IDLE SHALL be ignored; no command is lost because o_cmd_ready=0.
REQ-026 o_rsp_rdata and o_rsp_err SHALL hold their values until the next completion.

Reset
REQ-027 Asserting i_rstn=0 SHALL asynchronously force IDLE, all outputs to 0 and the watchdog to 0.
REQ-028 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp pulse.
REQ-029 o_cmd_ready SHALL go to 1 in the first cycle after reset release.

Configuration
REQ-030 With TPU_APB_TIMEOUT_EN defined, ACCESS lasting TIMEOUT cycles with i_pready=0 SHALL end the transfer with o_rsp_err=1 and o_rsp_rdata=0, and return to IDLE.
REQ-031 Without TPU_APB_TIMEOUT_EN, ACCESS SHALL wait for i_pready indefinitely and no watchdog logic SHALL exist.

Structure
REQ-032 A shared package tpu_apb_pkg SHALL hold the state typedef (IDLE/SETUP/ACCESS) and the TPU register constants (weight addresses 0..3, result read address 0).
REQ-033 SHALL be a single module with no sub-module; the watchdog is an inline counter.

Verification
REQ-034 Write addr=2, data=0x0000_0005, i_pready=1 -> SETUP in cycle 1 and ACCESS in cycle 2 with paddr=2 and pwdata=5, o_rsp_valid in cycle 3, o_rsp_err=0.
REQ-035 Read with i_prdata=0xDEAD_BEEF and i_pready low for 3 ACCESS cycles -> signals stay stable, rsp_rdata=0xDEADBEEF, 6-cycle latency.
REQ-036 Read with i_pslverr=1 at completion -> o_rsp_err=1, o_rsp_valid for 1 cycle.
REQ-037 Reset asserted mid-ACCESS -> all outputs 0 immediately, no rsp, o_cmd_ready=1 after release.
REQ-038 TPU_APB_TIMEOUT_EN with TIMEOUT=16 and i_pready held 0 -> err=1 after 16 ACCESS cycles; without the macro -> still waiting at cycle 100.
REQ-039 Against the tpu block: load weights 1,2,3,4, pulse start, read results 4 times -> rdata matches a reference 2x2 matmul.
